// File: rtl/rv32_dmem_pkg.sv
// Shared types for the RV32 data-memory bridge: FSM states, bus payload and timeout default.
package rv32_dmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  // Payload held on the bus for the whole request.
  typedef struct packed {
    logic              write;
    logic [MASK_W-1:0] mask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wvalue;
  } dmem_req_t;

endpackage

// File: rtl/rv32_dmem_bridge.sv
// Bridges the memory stage's single-cycle load/store port to a registered valid/ready bus.
// Optional access timeout with fault pulse: define RV32_DMEM_TIMEOUT_EN.
module rv32_dmem_bridge
  import rv32_dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_address_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        stall_out,
  output logic        fault_out,
  output logic        mem_valid_out,
  output logic        mem_write_out,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_address_out,
  output logic [31:0] mem_write_value_out,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_read_value_in
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rv32_dmem_bridge: TIMEOUT_CYCLES must be in 1..255");
  end

  dmem_state_e       state_q;
  dmem_req_t         req_q;
  logic              valid_q;
  logic [DATA_W-1:0] hold_q;
  logic              access;

`ifdef RV32_DMEM_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       fault_q;
`endif

  // A simultaneous read and write is resolved as a store.
  assign access = data_read_in | data_write_in;

  // Stall from the cycle an access is seen until the bus completes.
  assign stall_out = (state_q == REQ) || ((state_q == IDLE) && access);

  assign data_read_value_out = hold_q;
  assign mem_valid_out       = valid_q;
  assign mem_write_out       = req_q.write;
  assign mem_write_mask_out  = req_q.mask;
  assign mem_address_out     = req_q.addr;
  assign mem_write_value_out = req_q.wvalue;

`ifdef RV32_DMEM_TIMEOUT_EN
  assign fault_out = fault_q;
`else
  assign fault_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
`ifdef RV32_DMEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
`endif
    end else begin
`ifdef RV32_DMEM_TIMEOUT_EN
      fault_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (access) begin
            req_q.write  <= data_write_in;
            req_q.mask   <= data_write_in ? data_write_mask_in : '0;
            req_q.addr   <= data_address_in;
            req_q.wvalue <= data_write_value_in;
            valid_q      <= 1'b1;
            state_q      <= REQ;
`ifdef RV32_DMEM_TIMEOUT_EN
            cnt_q        <= 8'd0;
`endif
          end
        end
        REQ: begin
          if (mem_ready_in) begin
            valid_q <= 1'b0;
            if (!req_q.write) begin
              hold_q <= mem_read_value_in;
            end
            state_q <= DONE;
          end
`ifdef RV32_DMEM_TIMEOUT_EN
          // Abandon the request; the slave sees valid drop without a handshake.
          else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            valid_q <= 1'b0;
            hold_q  <= '0;
            fault_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        DONE: begin
          if (!stall_in) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_dmem_bridge.sv
// Scoreboard bench for rv32_dmem_bridge: directed accesses push expected bus and response items.
module tb_rv32_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        data_read_in = 1'b0;
  logic        data_write_in = 1'b0;
  logic [3:0]  data_write_mask_in = 4'h0;
  logic [31:0] data_address_in = 32'h0;
  logic [31:0] data_write_value_in = 32'h0;
  logic [31:0] data_read_value_out;
  logic        stall_out;
  logic        fault_out;
  logic        mem_valid_out;
  logic        mem_write_out;
  logic [3:0]  mem_write_mask_out;
  logic [31:0] mem_address_out;
  logic [31:0] mem_write_value_out;
  logic        mem_ready_in = 1'b0;
  logic [31:0] mem_read_value_in = 32'h0;

  rv32_dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .stall_in            (stall_in),
    .data_read_in        (data_read_in),
    .data_write_in       (data_write_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_address_in     (data_address_in),
    .data_write_value_in (data_write_value_in),
    .data_read_value_out (data_read_value_out),
    .stall_out           (stall_out),
    .fault_out           (fault_out),
    .mem_valid_out       (mem_valid_out),
    .mem_write_out       (mem_write_out),
    .mem_write_mask_out  (mem_write_mask_out),
    .mem_address_out     (mem_address_out),
    .mem_write_value_out (mem_write_value_out),
    .mem_ready_in        (mem_ready_in),
    .mem_read_value_in   (mem_read_value_in)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  int          checks = 0;
  int          failures = 0;
  bit          tie_ready = 1'b0;
  int          ready_delay = 0;
  int          req_cnt = 0;
  bit          skip_resp = 1'b0;
  logic [31:0] exp_hold = 32'h0;

  logic        bm_prev_v = 1'b0;
  logic        bm_wr;
  logic [3:0]  bm_mask;
  logic [31:0] bm_addr;
  logic [31:0] bm_wdata;
  int          bm_cycles = 0;
  bit          bm_stable = 1'b1;
  bus_exp_t    bm_e;

  logic        rm_prev_s = 1'b0;
  resp_exp_t   rm_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave model: ready either tied high or asserted after ready_delay REQ cycles.
  always @(negedge clk) begin
    if (tie_ready) begin
      mem_ready_in = 1'b1;
    end else if (mem_valid_out) begin
      mem_ready_in = (req_cnt >= ready_delay);
      req_cnt++;
    end else begin
      mem_ready_in = 1'b0;
      req_cnt = 0;
    end
  end

  // Bus monitor: one scoreboard pop per request, when valid falls.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mem_valid_out) begin
        if (!bm_prev_v) begin
          bm_wr     = mem_write_out;
          bm_mask   = mem_write_mask_out;
          bm_addr   = mem_address_out;
          bm_wdata  = mem_write_value_out;
          bm_cycles = 0;
          bm_stable = 1'b1;
        end else if ({mem_write_out, mem_write_mask_out, mem_address_out, mem_write_value_out}
                     != {bm_wr, bm_mask, bm_addr, bm_wdata}) begin
          bm_stable = 1'b0;
        end
        bm_cycles++;
      end else if (bm_prev_v) begin
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_extra_txn: got request to 0x%08h, want none at %0t", bm_addr, $time);
        end else begin
          bm_e = bus_q.pop_front();
          chk("bus_write", 32'(bm_wr), 32'(bm_e.wr));
          chk("bus_mask", 32'(bm_mask), 32'(bm_e.mask));
          chk("bus_addr", bm_addr, bm_e.addr);
          if (bm_e.wr) chk("bus_wdata", bm_wdata, bm_e.wdata);
          chk("bus_valid_cycles", 32'(bm_cycles), 32'(bm_e.cycles));
          chk("bus_payload_stable", 32'(bm_stable), 32'd1);
        end
      end
      bm_prev_v = mem_valid_out;
    end
  end

  // Response monitor: first cycle with stall_out low after a stall is the DONE cycle.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rm_prev_s && !stall_out) begin
        if (skip_resp) begin
          skip_resp = 1'b0;
        end else if (resp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_extra: got completion, want none at %0t", $time);
        end else begin
          rm_e = resp_q.pop_front();
          chk("rsp_fault", 32'(fault_out), 32'(rm_e.fault));
          chk("rsp_rdata", data_read_value_out, rm_e.data);
        end
      end
      rm_prev_s = stall_out;
    end
  end

  task automatic do_access(input logic rd, input logic wr, input logic [3:0] mask,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rval, input int req_cycles, input int delay,
                           input bit tie, input int done_hold, input bit exp_fault,
                           input string tag);
    bus_exp_t  b;
    resp_exp_t r;
    int        stalls = 0;
    bit        done = 1'b0;
    b.wr     = wr;
    b.mask   = wr ? mask : 4'b0000;
    b.addr   = addr;
    b.wdata  = wdata;
    b.cycles = req_cycles;
    bus_q.push_back(b);
    if (exp_fault) exp_hold = 32'h0;
    else if (!wr) exp_hold = rval;
    r.data  = exp_hold;
    r.fault = exp_fault;
    resp_q.push_back(r);
    tie_ready           = tie;
    ready_delay         = delay;
    mem_read_value_in   = rval;
    data_read_in        = rd;
    data_write_in       = wr;
    data_write_mask_in  = mask;
    data_address_in     = addr;
    data_write_value_in = wdata;
    for (int i = 0; i < 64 && !done; i++) begin
      #1;
      if (stall_out) begin
        stalls++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(1 + req_cycles));
    for (int k = 0; k < done_hold; k++) begin
      stall_in = 1'b1;
      @(negedge clk);
      #1;
      chk({tag, "_held_valid"}, 32'(mem_valid_out), 32'd0);
      chk({tag, "_held_stall"}, 32'(stall_out), 32'd0);
      chk({tag, "_held_rdata"}, data_read_value_out, exp_hold);
      chk({tag, "_held_fault"}, 32'(fault_out), 32'd0);
    end
    stall_in = 1'b0;
    @(negedge clk);
    data_read_in  = 1'b0;
    data_write_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want end by 200000 at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_exp_t rb;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(mem_valid_out), 32'd0);
    chk("rst_write", 32'(mem_write_out), 32'd0);
    chk("rst_mask", 32'(mem_write_mask_out), 32'd0);
    chk("rst_addr", mem_address_out, 32'd0);
    chk("rst_wvalue", mem_write_value_out, 32'd0);
    chk("rst_hold", data_read_value_out, 32'd0);
    chk("rst_fault", 32'(fault_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    do_access(1'b1, 1'b0, 4'hF, 32'h100, 32'h1111_1111, 32'hDEAD_BEEF, 1, 0, 1'b1, 0, 1'b0, "ld_tied");
    do_access(1'b0, 1'b1, 4'b0100, 32'h204, 32'h00AB_0000, 32'h5555_5555, 4, 3, 1'b0, 0, 1'b0, "st_delay3");
    do_access(1'b1, 1'b0, 4'h0, 32'h300, 32'h0, 32'h1234_5678, 1, 0, 1'b1, 0, 1'b0, "b2b_ld");
    do_access(1'b0, 1'b1, 4'hF, 32'h304, 32'hCAFE_F00D, 32'h0, 1, 0, 1'b1, 0, 1'b0, "b2b_st");
    do_access(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, 32'h0BAD_F00D, 2, 1, 1'b0, 2, 1'b0, "ld_done_stall");
    do_access(1'b1, 1'b1, 4'b0011, 32'h500, 32'h0000_BEEF, 32'h7777_7777, 1, 0, 1'b1, 0, 1'b0, "rd_wr_store");

    // Reset pulsed during REQ with the slave never answering.
    rb.wr = 1'b0; rb.mask = 4'h0; rb.addr = 32'h4A0; rb.wdata = 32'h0; rb.cycles = 2;
    bus_q.push_back(rb);
    tie_ready       = 1'b0;
    ready_delay     = 1000;
    data_read_in    = 1'b1;
    data_address_in = 32'h4A0;
    @(negedge clk);
    @(negedge clk);
    #5;
    skip_resp = 1'b1;
    reset_n   = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(mem_valid_out), 32'd0);
    chk("rst_mid_stall_access", 32'(stall_out), 32'd1);
    chk("rst_mid_hold", data_read_value_out, 32'd0);
    data_read_in = 1'b0;
    #1;
    chk("rst_mid_stall_idle", 32'(stall_out), 32'd0);
    #1;
    reset_n  = 1'b1;
    exp_hold = 32'h0;
    @(negedge clk);
    #1;
    chk("post_rst_valid", 32'(mem_valid_out), 32'd0);
    chk("post_rst_stall", 32'(stall_out), 32'd0);
    @(negedge clk);

    do_access(1'b1, 1'b0, 4'h0, 32'h600, 32'h0, 32'hA5A5_A5A5, 3, 2, 1'b0, 0, 1'b0, "ld_after_rst");
`ifdef RV32_DMEM_TIMEOUT_EN
    do_access(1'b1, 1'b0, 4'h0, 32'h700, 32'h0, 32'hFFFF_FFFF, 4, 1000, 1'b0, 1, 1'b1, "timeout");
`endif

    repeat (3) @(negedge clk);
    #5;
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    chk("rsp_queue_drained", 32'(resp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
